// File: rtl/apb4_pkg.sv
// Shared types and helpers for the APB4 1-to-N splitter.
package apb4_pkg;

  localparam int MAX_SLV = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FWD   = 2'd1,
    NOSLV = 2'd2
  } apb4_split_st_e;

  // One-hot of idx within the first n positions; all zeros if idx is out of range.
  function automatic logic [MAX_SLV-1:0] onehot(input logic [3:0] idx, input int n);
    logic [MAX_SLV-1:0] v;
    v = '0;
    if (int'(idx) < n) v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/apb4_addr_dec.sv
// Address window decoder: lowest-index window that matches (addr & mask) == base wins.
module apb4_addr_dec
  import apb4_pkg::*;
#(
  parameter int NUM_SLV = 4,
  parameter int ADDR_W  = 32,
  parameter int IDX_W   = 2,
  parameter logic [NUM_SLV-1:0][ADDR_W-1:0] SLV_BASE = '0,
  parameter logic [NUM_SLV-1:0][ADDR_W-1:0] SLV_MASK = '0
) (
  input  logic [ADDR_W-1:0]  addr,
  output logic               hit,
  output logic [IDX_W-1:0]   idx,
  output logic [NUM_SLV-1:0] sel
);

  logic [MAX_SLV-1:0] oh;

  always_comb begin
    hit = 1'b0;
    idx = '0;
    // Walk from the top down so the lowest matching index is the last writer.
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      if ((addr & SLV_MASK[i]) == SLV_BASE[i]) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

  assign oh  = onehot(4'(idx), NUM_SLV);
  assign sel = hit ? oh[NUM_SLV-1:0] : '0;

endmodule

// File: rtl/apb4_splitter.sv
// APB4 1-to-N bridge: decodes the master address, forwards to one slave, muxes the
// response back, and answers unmapped or stalled accesses with an error.
module apb4_splitter
  import apb4_pkg::*;
#(
  parameter int NUM_SLV    = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter logic [NUM_SLV-1:0][ADDR_W-1:0] SLV_BASE = '0,
  parameter logic [NUM_SLV-1:0][ADDR_W-1:0] SLV_MASK = '0,
  parameter int TMO_CYCLES = 255
) (
  input  logic                      pclk,
  input  logic                      presetn,
  input  logic [ADDR_W-1:0]         m_paddr,
  input  logic [2:0]                m_pprot,
  input  logic                      m_psel,
  input  logic                      m_penable,
  input  logic                      m_pwrite,
  input  logic [DATA_W-1:0]         m_pwdata,
  input  logic [DATA_W/8-1:0]       m_pstrb,
  output logic                      m_pready,
  output logic [DATA_W-1:0]         m_prdata,
  output logic                      m_pslverr,
  output logic [ADDR_W-1:0]         s_paddr,
  output logic [2:0]                s_pprot,
  output logic                      s_pwrite,
  output logic [DATA_W-1:0]         s_pwdata,
  output logic [DATA_W/8-1:0]       s_pstrb,
  output logic                      s_penable,
  output logic [NUM_SLV-1:0]        s_psel,
  input  logic [NUM_SLV-1:0]        s_pready,
  input  logic [NUM_SLV*DATA_W-1:0] s_prdata,
  input  logic [NUM_SLV-1:0]        s_pslverr,
  output logic                      dec_err_o,
  output logic                      tmo_err_o
);

  localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int CNT_W = (TMO_CYCLES > 0) ? $clog2(TMO_CYCLES + 1) : 1;
  localparam bit TMO_EN = (TMO_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(TMO_CYCLES);

  apb4_split_st_e     state_q, state_d;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               dec_hit;
  logic [IDX_W-1:0]   dec_idx;
  logic [NUM_SLV-1:0] dec_sel;
  logic [MAX_SLV-1:0] sel_oh_full;
  logic [DATA_W-1:0]  slv_rdata;

  apb4_addr_dec #(
    .NUM_SLV (NUM_SLV),
    .ADDR_W  (ADDR_W),
    .IDX_W   (IDX_W),
    .SLV_BASE(SLV_BASE),
    .SLV_MASK(SLV_MASK)
  ) u_dec (
    .addr(m_paddr),
    .hit (dec_hit),
    .idx (dec_idx),
    .sel (dec_sel)
  );

  assign s_paddr   = m_paddr;
  assign s_pprot   = m_pprot;
  assign s_pwrite  = m_pwrite;
  assign s_pwdata  = m_pwdata;
  assign s_pstrb   = m_pstrb;
  assign s_penable = m_penable;

  assign sel_oh_full = onehot(4'(sel_q), NUM_SLV);
  assign slv_rdata   = s_prdata[int'(sel_q)*DATA_W +: DATA_W];

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  // Handshake: a transfer is a setup cycle (psel & ~penable) followed by access cycles
  // (psel & penable); it completes in the access cycle where m_pready is 1, and the
  // response fields are only meaningful in that cycle.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    s_psel    = '0;
    m_pready  = 1'b0;
    m_prdata  = '0;
    m_pslverr = 1'b0;
    dec_err_o = 1'b0;
    tmo_err_o = 1'b0;
    // Combinational outputs are forced quiet while reset is held.
    if (presetn) begin
      case (state_q)
        IDLE: begin
          if (m_psel && !m_penable) begin
            s_psel = dec_sel;
            if (dec_hit) begin
              sel_d   = dec_idx;
              state_d = FWD;
            end else begin
              state_d = NOSLV;
            end
          end else if (m_psel && m_penable) begin
            m_pready  = 1'b1;
            m_pslverr = 1'b1;
          end
        end
        FWD: begin
          if (!m_psel) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            s_psel = sel_oh_full[NUM_SLV-1:0];
            if (m_penable) begin
              m_prdata  = slv_rdata;
              m_pslverr = s_pslverr[sel_q];
              if (s_pready[sel_q]) begin
                m_pready = 1'b1;
                state_d  = IDLE;
                cnt_d    = '0;
              end else if (TMO_EN && (cnt_q == TMO_VAL)) begin
                m_pready  = 1'b1;
                m_pslverr = 1'b1;
                m_prdata  = '0;
                tmo_err_o = 1'b1;
                state_d   = IDLE;
                cnt_d     = '0;
              end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
              end
            end
          end
        end
        NOSLV: begin
          if (!m_psel) begin
            state_d = IDLE;
          end else if (m_penable) begin
            m_pready  = 1'b1;
            m_pslverr = 1'b1;
            dec_err_o = 1'b1;
            state_d   = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb4_splitter.sv
// Bench for apb4_splitter: reactive slave models plus a transfer-level reference model.
module tb_apb4_splitter;

  localparam int NS  = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;
  localparam int TMO = 8;
  localparam logic [NS-1:0][AW-1:0] BASE = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000};
  localparam logic [NS-1:0][AW-1:0] MASK = {4{32'h0000_F000}};

  logic             pclk;
  logic             presetn;
  logic [AW-1:0]    m_paddr;
  logic [2:0]       m_pprot;
  logic             m_psel;
  logic             m_penable;
  logic             m_pwrite;
  logic [DW-1:0]    m_pwdata;
  logic [SW-1:0]    m_pstrb;
  logic             m_pready;
  logic [DW-1:0]    m_prdata;
  logic             m_pslverr;
  logic [AW-1:0]    s_paddr;
  logic [2:0]       s_pprot;
  logic             s_pwrite;
  logic [DW-1:0]    s_pwdata;
  logic [SW-1:0]    s_pstrb;
  logic             s_penable;
  logic [NS-1:0]    s_psel;
  logic [NS-1:0]    s_pready;
  logic [NS*DW-1:0] s_prdata;
  logic [NS-1:0]    s_pslverr;
  logic             dec_err_o;
  logic             tmo_err_o;

  int n_checks = 0;
  int n_fail   = 0;

  int            wait_cfg[NS]   = '{default: 0};
  logic [DW-1:0] rdata_cfg[NS]  = '{default: '0};
  logic          err_cfg[NS]    = '{default: 1'b0};
  int            acc_cnt[NS]    = '{default: 0};
  logic [DW-1:0] last_wdata[NS] = '{default: '0};

  apb4_splitter #(
    .NUM_SLV   (NS),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .SLV_BASE  (BASE),
    .SLV_MASK  (MASK),
    .TMO_CYCLES(TMO)
  ) dut (
    .pclk     (pclk),
    .presetn  (presetn),
    .m_paddr  (m_paddr),
    .m_pprot  (m_pprot),
    .m_psel   (m_psel),
    .m_penable(m_penable),
    .m_pwrite (m_pwrite),
    .m_pwdata (m_pwdata),
    .m_pstrb  (m_pstrb),
    .m_pready (m_pready),
    .m_prdata (m_prdata),
    .m_pslverr(m_pslverr),
    .s_paddr  (s_paddr),
    .s_pprot  (s_pprot),
    .s_pwrite (s_pwrite),
    .s_pwdata (s_pwdata),
    .s_pstrb  (s_pstrb),
    .s_penable(s_penable),
    .s_psel   (s_psel),
    .s_pready (s_pready),
    .s_prdata (s_prdata),
    .s_pslverr(s_pslverr),
    .dec_err_o(dec_err_o),
    .tmo_err_o(tmo_err_o)
  );

  // Clock and reset
  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  // Slave i raises pready after wait_cfg[i] stalled access cycles.
  always_comb begin
    s_pready  = '0;
    s_prdata  = '0;
    s_pslverr = '0;
    for (int i = 0; i < NS; i++) begin
      s_pready[i]            = s_psel[i] & s_penable & (acc_cnt[i] >= wait_cfg[i]);
      s_prdata[i*DW +: DW]   = rdata_cfg[i];
      s_pslverr[i]           = err_cfg[i];
    end
  end

  always @(posedge pclk) begin
    for (int i = 0; i < NS; i++) begin
      if (s_psel[i] && s_penable && !s_pready[i]) acc_cnt[i] <= acc_cnt[i] + 1;
      else acc_cnt[i] <= 0;
      if (s_psel[i] && s_penable && s_pready[i] && s_pwrite) last_wdata[i] <= s_pwdata;
    end
  end

  function automatic int ref_target(input logic [AW-1:0] a);
    logic [AW-1:0] b, m;
    for (int i = 0; i < NS; i++) begin
      b = BASE[i];
      m = MASK[i];
      if ((a & m) == b) return i;
    end
    return -1;
  endfunction

  // One complete transfer, started just after a rising edge; returns just after the
  // edge that ends it, with psel/penable low.
  task automatic apb_xfer(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wdata,
                          input string name);
    int tgt, exp_acc, acc;
    logic [NS-1:0] exp_sel;
    logic exp_err, exp_dec, exp_tmo, got_rdy, got_err, got_dec, got_tmo, early, sel_bad;
    logic [DW-1:0] exp_rd, got_rd;
    logic [SW-1:0] strb;
    logic [2:0] prot;
    tgt = ref_target(addr);
    exp_sel = '0;
    exp_dec = 1'b0;
    exp_tmo = 1'b0;
    if (tgt < 0) begin
      exp_acc = 1; exp_err = 1'b1; exp_dec = 1'b1; exp_rd = '0;
    end else begin
      exp_sel[tgt] = 1'b1;
      if (wait_cfg[tgt] <= TMO) begin
        exp_acc = wait_cfg[tgt] + 1; exp_err = err_cfg[tgt]; exp_rd = rdata_cfg[tgt];
      end else begin
        exp_acc = TMO + 1; exp_err = 1'b1; exp_tmo = 1'b1; exp_rd = '0;
      end
    end
    strb = SW'($urandom);
    prot = 3'($urandom);
    m_paddr = addr; m_pwrite = wr; m_pwdata = wdata; m_pstrb = strb; m_pprot = prot;
    m_psel = 1'b1; m_penable = 1'b0;
    @(negedge pclk);
    n_checks++;
    if (s_psel !== exp_sel) begin
      n_fail++; $display("FAIL %s setup_sel: got %b expected %b", name, s_psel, exp_sel);
    end
    n_checks++;
    if ({s_paddr, s_pwdata, s_pstrb, s_pwrite, s_pprot, s_penable} !== {addr, wdata, strb, wr, prot, 1'b0}) begin
      n_fail++; $display("FAIL %s broadcast: got %h/%h expected %h/%h", name, s_paddr, s_pwdata, addr, wdata);
    end
    n_checks++;
    if (m_pready !== 1'b0) begin
      n_fail++; $display("FAIL %s setup_ready: got %b expected 0", name, m_pready);
    end
    @(posedge pclk); #1;
    m_penable = 1'b1;
    acc = 0; got_rdy = 0; early = 0; sel_bad = 0;
    got_err = 0; got_dec = 0; got_tmo = 0; got_rd = '0;
    while (!got_rdy && acc < 40) begin
      acc++;
      @(negedge pclk);
      if (s_psel !== exp_sel) sel_bad = 1'b1;
      if (m_pready === 1'b1) begin
        got_rdy = 1'b1; got_err = m_pslverr; got_dec = dec_err_o; got_tmo = tmo_err_o; got_rd = m_prdata;
      end else begin
        if (dec_err_o || tmo_err_o) early = 1'b1;
        @(posedge pclk); #1;
      end
    end
    n_checks++;
    if (!got_rdy) begin
      n_fail++; $display("FAIL %s completion: no pready within %0d cycles, expected at %0d", name, acc, exp_acc);
    end
    n_checks++;
    if (acc != exp_acc) begin
      n_fail++; $display("FAIL %s latency: got %0d access cycles expected %0d", name, acc, exp_acc);
    end
    n_checks++;
    if ({got_err, got_dec, got_tmo} !== {exp_err, exp_dec, exp_tmo}) begin
      n_fail++; $display("FAIL %s err/dec/tmo: got %b%b%b expected %b%b%b", name, got_err, got_dec, got_tmo,
                         exp_err, exp_dec, exp_tmo);
    end
    n_checks++;
    if (got_rd !== exp_rd) begin
      n_fail++; $display("FAIL %s prdata: got %h expected %h", name, got_rd, exp_rd);
    end
    n_checks++;
    if (early || sel_bad) begin
      n_fail++; $display("FAIL %s access_phase: early_pulse=%b sel_wrong=%b expected 0/0", name, early, sel_bad);
    end
    @(posedge pclk); #1;
    m_psel = 1'b0; m_penable = 1'b0;
    if (wr && tgt >= 0 && !exp_tmo) begin
      n_checks++;
      if (last_wdata[tgt] !== wdata) begin
        n_fail++; $display("FAIL %s wdata: slave %0d got %h expected %h", name, tgt, last_wdata[tgt], wdata);
      end
    end
  endtask

  task automatic idle_cycle();
    m_psel = 1'b0; m_penable = 1'b0;
    @(posedge pclk); #1;
  endtask

  task automatic test_reset();
    presetn = 1'b1;
    m_paddr = 32'h2004; m_pprot = '0; m_pwrite = 1'b0; m_pwdata = '0; m_pstrb = '0;
    m_psel = 1'b1; m_penable = 1'b0;
    #2 presetn = 1'b0;
    @(negedge pclk);
    n_checks++;
    if ({s_psel, m_pready, m_prdata, m_pslverr, dec_err_o, tmo_err_o} !== '0) begin
      n_fail++; $display("FAIL reset_setup: got sel=%b rdy=%b rd=%h err=%b expected all 0", s_psel, m_pready, m_prdata, m_pslverr);
    end
    m_penable = 1'b1;
    @(negedge pclk);
    n_checks++;
    if ({s_psel, m_pready, m_prdata, m_pslverr} !== '0) begin
      n_fail++; $display("FAIL reset_access: got sel=%b rdy=%b rd=%h expected all 0", s_psel, m_pready, m_prdata);
    end
    m_psel = 1'b0; m_penable = 1'b0;
    @(posedge pclk); #1;
    presetn = 1'b1;
    @(posedge pclk); #1;
  endtask

  task automatic test_write_zero_wait();
    wait_cfg = '{default: 0};
    apb_xfer(32'h2004, 1'b1, 32'hA5A5_1234, "write_s2");
  endtask

  task automatic test_read_wait();
    wait_cfg[1] = 3; rdata_cfg[1] = 32'hDEAD_BEEF; err_cfg[1] = 1'b0;
    apb_xfer(32'h1010, 1'b0, '0, "read_s1_wait3");
  endtask

  task automatic test_unmapped();
    apb_xfer(32'h9000, 1'b0, '0, "unmapped");
    idle_cycle();
    apb_xfer(32'h9000, 1'b1, 32'h1111_2222, "unmapped_wr");
  endtask

  task automatic test_timeout();
    wait_cfg[0] = 255; rdata_cfg[0] = 32'h0BAD_F00D; err_cfg[0] = 1'b0;
    apb_xfer(32'h0008, 1'b0, '0, "timeout_s0");
    // Holding psel+penable after completion is a violation answered from idle.
    m_psel = 1'b1; m_penable = 1'b1;
    @(negedge pclk);
    n_checks++;
    if ({s_psel, m_pready, m_pslverr, m_prdata, dec_err_o, tmo_err_o} !== {4'b0000, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL post_timeout_violation: got sel=%b rdy=%b err=%b rd=%h dec=%b tmo=%b expected 0000 1 1 0 0 0",
                         s_psel, m_pready, m_pslverr, m_prdata, dec_err_o, tmo_err_o);
    end
    @(posedge pclk); #1;
    idle_cycle();
    wait_cfg[0] = TMO; err_cfg[0] = 1'b1;
    apb_xfer(32'h0010, 1'b0, '0, "tmo_coincide");
    wait_cfg[0] = 0; err_cfg[0] = 1'b0;
  endtask

  task automatic test_back_to_back();
    wait_cfg = '{default: 0};
    rdata_cfg[3] = 32'h3333_0003; rdata_cfg[0] = 32'h0000_0F00;
    apb_xfer(32'h3ABC, 1'b1, 32'hCAFE_0003, "b2b_s3");
    apb_xfer(32'h0040, 1'b0, '0, "b2b_s0");
    apb_xfer(32'h2040, 1'b0, '0, "b2b_s2");
    idle_cycle();
  endtask

  task automatic test_psel_drop();
    wait_cfg[1] = 255;
    m_paddr = 32'h1000; m_pwrite = 1'b0; m_psel = 1'b1; m_penable = 1'b0;
    @(posedge pclk); #1;
    m_penable = 1'b1;
    @(posedge pclk); #1;
    m_psel = 1'b0; m_penable = 1'b0;
    @(negedge pclk);
    n_checks++;
    if ({s_psel, m_pready, dec_err_o, tmo_err_o} !== '0) begin
      n_fail++; $display("FAIL psel_drop: got sel=%b rdy=%b dec=%b tmo=%b expected 0", s_psel, m_pready, dec_err_o, tmo_err_o);
    end
    @(posedge pclk); #1;
    wait_cfg[1] = 2; rdata_cfg[1] = 32'h5555_AAAA;
    apb_xfer(32'h1004, 1'b0, '0, "after_psel_drop");
  endtask

  task automatic test_reset_mid();
    wait_cfg[1] = 255;
    m_paddr = 32'h1000; m_pwrite = 1'b0; m_psel = 1'b1; m_penable = 1'b0;
    @(posedge pclk); #1;
    m_penable = 1'b1;
    @(posedge pclk); #1;
    @(posedge pclk); #1;
    n_checks++;
    if (s_psel !== 4'b0010) begin
      n_fail++; $display("FAIL pre_reset_sel: got %b expected 0010", s_psel);
    end
    presetn = 1'b0;
    #1;
    n_checks++;
    if ({s_psel, m_pready, m_prdata, m_pslverr, dec_err_o, tmo_err_o} !== '0) begin
      n_fail++; $display("FAIL reset_mid: got sel=%b rdy=%b rd=%h err=%b expected all 0", s_psel, m_pready, m_prdata, m_pslverr);
    end
    m_psel = 1'b0; m_penable = 1'b0;
    @(posedge pclk); #1;
    presetn = 1'b1;
    @(posedge pclk); #1;
    wait_cfg[1] = 6;
    apb_xfer(32'h1008, 1'b0, '0, "after_reset_mid");
  endtask

  task automatic test_random();
    int r;
    logic [AW-1:0] a;
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NS; i++) begin
        wait_cfg[i]  = $urandom_range(0, 11);
        rdata_cfg[i] = $urandom;
        err_cfg[i]   = 1'($urandom_range(0, 1));
      end
      r = $urandom_range(0, 5);
      if (r < 4) a = (AW'(r) << 12) | AW'($urandom_range(0, 4095));
      else a = (AW'($urandom_range(4, 15)) << 12) | AW'($urandom_range(0, 4095));
      apb_xfer(a, 1'($urandom_range(0, 1)), $urandom, $sformatf("rand%0d", n));
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_unmapped();
    test_timeout();
    test_back_to_back();
    test_psel_drop();
    test_reset_mid();
    test_random();
    repeat (2) @(posedge pclk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
